// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock/tick generator
// Each channel toggles ClkOut every D+1 cycles; divisor changes land only on half-period boundaries.
module clk_div_multi #(
    parameter int NCH         = 4,
    parameter int W           = 26,
    parameter int DIV_DEFAULT = 10000,
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [NCH-1:0] En,
    input  logic           Sync,
    input  logic           CfgWr,
    input  logic [CW-1:0]  CfgCh,
    input  logic [W-1:0]   CfgDiv,
    output logic [NCH-1:0] ClkOut,
    output logic [NCH-1:0] Tick,
    output logic [NCH-1:0] CfgPend
);

    logic [W-1:0]   cnt_q      [NCH];
    logic [W-1:0]   cnt_d      [NCH];
    logic [W-1:0]   div_cur_q  [NCH];
    logic [W-1:0]   div_cur_d  [NCH];
    logic [W-1:0]   div_pend_q [NCH];
    logic [W-1:0]   div_pend_d [NCH];
    logic [NCH-1:0] clk_out_q, clk_out_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] pend_q, pend_d;

    always_comb begin
        clk_out_d = clk_out_q;
        tick_d    = tick_q;
        pend_d    = pend_q;
        for (int i = 0; i < NCH; i++) begin : ch_next
            logic wr;
            logic bnd;
            cnt_d[i]      = cnt_q[i];
            div_cur_d[i]  = div_cur_q[i];
            div_pend_d[i] = div_pend_q[i];
            // Out-of-range CfgCh never matches any channel index, so it is ignored.
            wr  = CfgWr && (CfgCh == CW'(i));
            bnd = (cnt_q[i] == div_cur_q[i]);
            if (!En[i]) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
                if (wr) begin
                    div_cur_d[i] = CfgDiv;
                    pend_d[i]    = 1'b0;
                end
            end else if (Sync || bnd) begin
                // cnt restarts here, so a direct divisor load can never leave cnt above it.
                cnt_d[i] = '0;
                if (Sync) begin
                    clk_out_d[i] = 1'b0;
                    tick_d[i]    = 1'b0;
                end else begin
                    clk_out_d[i] = ~clk_out_q[i];
                    tick_d[i]    = ~clk_out_q[i];
                end
                if (wr) begin
                    div_cur_d[i] = CfgDiv;
                end else if (pend_q[i]) begin
                    div_cur_d[i] = div_pend_q[i];
                end
                pend_d[i] = 1'b0;
            end else begin
                cnt_d[i]  = cnt_q[i] + 1'b1;
                tick_d[i] = 1'b0;
                if (wr) begin
                    div_pend_d[i] = CfgDiv;
                    pend_d[i]     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]      <= '0;
                div_cur_q[i]  <= W'(DIV_DEFAULT);
                div_pend_q[i] <= '0;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
            pend_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]      <= cnt_d[i];
                div_cur_q[i]  <= div_cur_d[i];
                div_pend_q[i] <= div_pend_d[i];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
        end
    end

    assign ClkOut  = clk_out_q;
    assign Tick    = tick_q;
    assign CfgPend = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
// Five channels so that CfgCh=5 is representable and out of range.
module tb_clk_div_multi;

    localparam int NCH = 5;
    localparam int W   = 8;
    localparam int CW  = 3;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [NCH-1:0] En;
    logic           Sync;
    logic           CfgWr;
    logic [CW-1:0]  CfgCh;
    logic [W-1:0]   CfgDiv;
    logic [NCH-1:0] ClkOut;
    logic [NCH-1:0] Tick;
    logic [NCH-1:0] CfgPend;

    int vectors    = 0;
    int miscompares = 0;

    clk_div_multi #(.NCH(NCH), .W(W), .DIV_DEFAULT(3)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Sync(Sync), .CfgWr(CfgWr),
        .CfgCh(CfgCh), .CfgDiv(CfgDiv), .ClkOut(ClkOut), .Tick(Tick),
        .CfgPend(CfgPend)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
        CfgWr = 1'b0;
        Sync  = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1; En = '0; Sync = 1'b0; CfgWr = 1'b0; CfgCh = '0; CfgDiv = '0;
        repeat (3) step();
        Rst = 1'b0;
    endtask

    task automatic cfg(input logic [CW-1:0] ch, input logic [W-1:0] d);
        CfgWr = 1'b1; CfgCh = ch; CfgDiv = d;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({ClkOut, Tick, CfgPend} !== '0) begin
            miscompares++;
            $display("FAIL reset: outputs=%h required 0", {ClkOut, Tick, CfgPend});
        end
    endtask

    task automatic test_default_run();
        logic eclk, etick;
        do_reset();
        En = 5'b00001;
        for (int k = 1; k <= 16; k++) begin
            step();
            eclk  = ((k / 4) % 2) == 1;
            etick = (k % 8) == 4;
            vectors++;
            if (ClkOut !== {4'b0, eclk} || Tick !== {4'b0, etick}) begin
                miscompares++;
                $display("FAIL default_run edge %0d: ClkOut=%b Tick=%b required %b %b",
                         k, ClkOut, Tick, {4'b0, eclk}, {4'b0, etick});
            end
        end
    endtask

    task automatic test_div0_disabled_write();
        do_reset();
        cfg(3'd1, 8'd0);
        step();
        vectors++;
        if (CfgPend !== '0) begin
            miscompares++;
            $display("FAIL div0_pend: CfgPend=%b required 0", CfgPend);
        end
        En = 5'b00010;
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++;
            if (ClkOut[1] !== k[0] || Tick[1] !== k[0]) begin
                miscompares++;
                $display("FAIL div0 edge %0d: ClkOut1=%b Tick1=%b required %b", k, ClkOut[1], Tick[1], k[0]);
            end
        end
    endtask

    task automatic test_pending_update();
        logic eclk, etick, epend;
        do_reset();
        cfg(3'd0, 8'd9);
        step();
        En = 5'b00001;
        repeat (4) step();
        cfg(3'd0, 8'd2);
        for (int k = 5; k <= 16; k++) begin
            step();
            eclk  = (k >= 10 && k < 13) || k >= 16;
            etick = (k == 10) || (k == 16);
            epend = k < 10;
            vectors++;
            if (ClkOut[0] !== eclk || Tick[0] !== etick || CfgPend[0] !== epend) begin
                miscompares++;
                $display("FAIL pending edge %0d: clk=%b tick=%b pend=%b required %b %b %b",
                         k, ClkOut[0], Tick[0], CfgPend[0], eclk, etick, epend);
            end
        end
    endtask

    task automatic test_sync();
        logic e;
        do_reset();
        cfg(3'd0, 8'd5); step();
        cfg(3'd2, 8'd5); step();
        En = 5'b00001;
        repeat (2) step();
        En = 5'b00101;
        repeat (3) step();
        Sync = 1'b1;
        step();
        vectors++;
        if (ClkOut !== '0 || Tick !== '0) begin
            miscompares++;
            $display("FAIL sync_clear: ClkOut=%b Tick=%b required 0 0", ClkOut, Tick);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            e = (k == 6);
            vectors++;
            if (ClkOut[0] !== e || ClkOut[2] !== e || Tick[0] !== e || Tick[2] !== e) begin
                miscompares++;
                $display("FAIL sync edge %0d: ClkOut=%b Tick=%b required ch0/ch2=%b", k, ClkOut, Tick, e);
            end
        end
    endtask

    task automatic test_cfg_edge_cases();
        logic eclk;
        do_reset();
        En = 5'b00001;
        cfg(3'd5, 8'd7);
        step();
        vectors++;
        if (CfgPend !== '0) begin
            miscompares++;
            $display("FAIL bad_ch_pend: CfgPend=%b required 0", CfgPend);
        end
        repeat (3) step();
        vectors++;
        if (ClkOut !== 5'b00001 || Tick !== 5'b00001) begin
            miscompares++;
            $display("FAIL bad_ch_rise: ClkOut=%b Tick=%b required 00001 00001", ClkOut, Tick);
        end
        repeat (3) step();
        cfg(3'd0, 8'd1);
        for (int k = 8; k <= 12; k++) begin
            step();
            eclk = (k == 10) || (k == 11);
            vectors++;
            if (ClkOut[0] !== eclk || CfgPend[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL boundary_wr edge %0d: clk=%b pend=%b required %b 0", k, ClkOut[0], CfgPend[0], eclk);
            end
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        En = 5'b00001;
        repeat (2) step();
        cfg(3'd0, 8'd6);
        step();
        vectors++;
        if (CfgPend[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pend_set: CfgPend0=%b required 1", CfgPend[0]);
        end
        Rst = 1'b1;
        step();
        vectors++;
        if ({ClkOut, Tick, CfgPend} !== '0) begin
            miscompares++;
            $display("FAIL abort_clear: outputs=%h required 0", {ClkOut, Tick, CfgPend});
        end
        Rst = 1'b0;
        repeat (3) step();
        vectors++;
        if (ClkOut[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_edge3: clk=%b required 0", ClkOut[0]);
        end
        step();
        vectors++;
        if (ClkOut[0] !== 1'b1 || Tick[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_default_div: clk=%b tick=%b required 1 1", ClkOut[0], Tick[0]);
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_div0_disabled_write();
        test_pending_update();
        test_sync();
        test_cfg_edge_cases();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
